// File: rtl/ps2_pkg.sv
// PS/2 receiver shared definitions.
// Prefix bytes, frame FSM states and packed-code layout.
package ps2_pkg;

  localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

  localparam int EXT_BIT = 9;
  localparam int BRK_BIT = 8;
  localparam int CODE_W  = 10;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } ps2_state_e;

  function automatic logic [CODE_W-1:0] ps2_pack(
    input logic       ext,
    input logic       brk,
    input logic [7:0] code
  );
    logic [CODE_W-1:0] p;
    p          = '0;
    p[EXT_BIT] = ext;
    p[BRK_BIT] = brk;
    p[7:0]     = code;
    return p;
  endfunction

endpackage

// File: rtl/ps2_code_fifo.sv
// Generic first-word-fall-through FIFO.
// Head holds the last popped word while empty.
module ps2_code_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] last_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = empty_o ? last_q : mem_q[rd_q];
  assign count_o = cnt_q;

  // Storage array, written on accepted push.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_q] <= data_i;
    end
  end

  // Pointers, occupancy and last-popped head.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      if (do_push) begin
        wr_q <= wr_q + 1'b1;
      end
      if (do_pop) begin
        rd_q   <= rd_q + 1'b1;
        last_q <= mem_q[rd_q];
      end
      if (do_push && !do_pop) begin
        cnt_q <= cnt_q + 1'b1;
      end else if (do_pop && !do_push) begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: sync, glitch filter, frame check,
// timeout, E0/F0 prefix decode and a FWFT code FIFO.
module ps2_kbd_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 3,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            ps2_clk,
  input  logic                            ps2_data,
  output logic [9:0]                      out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            parity_err,
  output logic                            frame_err,
  output logic                            overflow
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] dat_sync_q;
  logic                   clk_s;
  logic                   dat_s;

  logic [FW-1:0] flt_cnt_q;
  logic [FW-1:0] flt_cnt_d;
  logic          flt_q;
  logic          flt_d;
  logic          fall_q;

  ps2_state_e    state_q;
  ps2_state_e    state_d;
  logic [2:0]    bit_q;
  logic [2:0]    bit_d;
  logic [7:0]    sh_q;
  logic [7:0]    sh_d;
  logic          par_q;
  logic          par_d;
  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_d;
  logic          ext_q;
  logic          ext_d;
  logic          brk_q;
  logic          brk_d;
  logic          perr_q;
  logic          perr_d;
  logic          ferr_q;
  logic          ferr_d;
  logic          ovf_q;
  logic          ovf_d;

  logic                  push;
  logic [CODE_W-1:0]     push_code;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign clk_s = clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  // Pin synchronisers, preset to the idle-high bus level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Filter: flip only after FILTER_LEN differing samples in a row.
  always_comb begin
    flt_d     = flt_q;
    flt_cnt_d = '0;
    if (clk_s != flt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
        flt_d = clk_s;
      end else begin
        flt_cnt_d = flt_cnt_q + 1'b1;
      end
    end
  end

  // Filter state and registered falling-edge strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flt_q     <= 1'b1;
      flt_cnt_q <= '0;
      fall_q    <= 1'b0;
    end else begin
      flt_q     <= flt_d;
      flt_cnt_q <= flt_cnt_d;
      fall_q    <= flt_q & ~flt_d;
    end
  end

  // Frame FSM, timeout, prefix decode and error pulses.
  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    par_d     = par_q;
    tmo_d     = tmo_q;
    ext_d     = ext_q;
    brk_d     = brk_q;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    push      = 1'b0;
    push_code = ps2_pack(ext_q, brk_q, sh_q);
    if (fall_q) begin
      tmo_d = '0;
      unique case (state_q)
        IDLE: begin
          if (!dat_s) begin
            state_d = DATA;
            bit_d   = 3'd0;
          end
        end
        DATA: begin
          sh_d  = {dat_s, sh_q[7:1]};
          bit_d = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          par_d   = dat_s;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!dat_s) begin
            ferr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end else if (((^sh_q) ^ par_q) == 1'b0) begin
            perr_d = 1'b1;
            ext_d  = 1'b0;
            brk_d  = 1'b0;
          end else if (sh_q == PS2_PFX_EXT) begin
            ext_d = 1'b1;
          end else if (sh_q == PS2_PFX_BRK) begin
            brk_d = 1'b1;
          end else begin
            push  = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
        state_d = IDLE;
        tmo_d   = '0;
        bit_d   = 3'd0;
        sh_d    = '0;
        ferr_d  = 1'b1;
        ext_d   = 1'b0;
        brk_d   = 1'b0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  assign ovf_d = push && fifo_full && !(out_valid && out_ready);

  // Frame FSM and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tmo_q   <= '0;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      tmo_q   <= tmo_d;
      ext_q   <= ext_d;
      brk_q   <= brk_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovf_q   <= ovf_d;
    end
  end

  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overflow   = ovf_q;
  assign out_valid  = !fifo_empty;

  ps2_code_fifo #(
    .WIDTH (CODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .data_i  (push_code),
    .pop_i   (out_ready),
    .data_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx.
// Frames are bit-banged on the PS/2 pins in clk-aligned steps.
module tb_ps2_kbd_rx;

  localparam int SYNC    = 3;
  localparam int FLT     = 4;
  localparam int TMO     = 1000;
  localparam int DEPTH   = 8;
  localparam int HALF    = 20;
  localparam int LAT_MAX = SYNC + FLT + 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [9:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] fifo_count;
  logic       parity_err;
  logic       frame_err;
  logic       overflow;

  int n_tests  = 0;
  int n_fail   = 0;
  int perr_n   = 0;
  int ferr_n   = 0;
  int ovf_n    = 0;
  int pop_at   = 0;
  int push_cyc = 0;
  int val_cyc  = 0;

  ps2_kbd_rx #(
    .SYNC_STAGES    (SYNC),
    .FILTER_LEN     (FLT),
    .TIMEOUT_CYCLES (TMO),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .fifo_count (fifo_count),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (parity_err) perr_n++;
    if (frame_err)  ferr_n++;
    if (overflow)   ovf_n++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk(
    input logic [7:0] b,
    input logic       bad_par,
    input logic       bad_stop
  );
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] f, input int nbits);
    logic [3:0] c0;
    logic       v0;
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      tick(HALF);
      ps2_clk = 1'b0;
      if (i == 10) begin
        c0       = fifo_count;
        v0       = out_valid;
        push_cyc = 0;
        val_cyc  = 0;
        for (int k = 1; k <= HALF; k++) begin
          @(negedge clk);
          if (push_cyc == 0 && fifo_count != c0) push_cyc = k;
          if (val_cyc == 0 && !v0 && out_valid) val_cyc = k;
          if (pop_at != 0) out_ready = (k == pop_at - 1);
        end
      end else begin
        tick(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_bits(mk(b, 1'b0, 1'b0), 11);
    tick(HALF);
  endtask

  task automatic pop1(output logic [9:0] d, output logic v);
    v = out_valid;
    d = out_data;
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    out_ready = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(3);
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid got %b exp 0", out_valid);
    end
    n_tests++;
    if (out_data !== 10'h000) begin
      n_fail++;
      $display("FAIL reset_data got %h exp 000", out_data);
    end
    n_tests++;
    if (fifo_count !== 4'd0 || parity_err !== 1'b0 ||
        frame_err !== 1'b0 || overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_misc cnt %0d pe %b fe %b ov %b exp 0",
               fifo_count, parity_err, frame_err, overflow);
    end
  endtask

  task automatic test_make;
    logic [9:0] d;
    logic       v;
    send_byte(8'h1C);
    n_tests++;
    if (val_cyc < 1 || val_cyc > LAT_MAX) begin
      n_fail++;
      $display("FAIL make_latency got %0d exp 1..%0d", val_cyc, LAT_MAX);
    end
    n_tests++;
    if (fifo_count !== 4'd1) begin
      n_fail++;
      $display("FAIL make_count got %0d exp 1", fifo_count);
    end
    pop1(d, v);
    n_tests++;
    if (v !== 1'b1 || d !== 10'h01C) begin
      n_fail++;
      $display("FAIL make_data got v%b %h exp v1 01C", v, d);
    end
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL make_drain got %b exp 0", out_valid);
    end
  endtask

  task automatic test_prefix;
    logic [9:0] d;
    logic       v;
    send_byte(8'hF0);
    send_byte(8'h1C);
    pop1(d, v);
    n_tests++;
    if (v !== 1'b1 || d !== 10'h11C) begin
      n_fail++;
      $display("FAIL pfx_break got v%b %h exp v1 11C", v, d);
    end
    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h75);
    n_tests++;
    if (fifo_count !== 4'd1) begin
      n_fail++;
      $display("FAIL pfx_ext_brk_count got %0d exp 1", fifo_count);
    end
    pop1(d, v);
    n_tests++;
    if (v !== 1'b1 || d !== 10'h375) begin
      n_fail++;
      $display("FAIL pfx_ext_brk got v%b %h exp v1 375", v, d);
    end
    send_byte(8'hE0);
    send_byte(8'h75);
    pop1(d, v);
    n_tests++;
    if (v !== 1'b1 || d !== 10'h275) begin
      n_fail++;
      $display("FAIL pfx_ext got v%b %h exp v1 275", v, d);
    end
  endtask

  task automatic test_errors;
    logic [9:0] d;
    logic       v;
    int         p0;
    int         f0;
    p0 = perr_n;
    f0 = ferr_n;
    send_bits(mk(8'h1C, 1'b1, 1'b0), 11);
    tick(HALF);
    n_tests++;
    if (perr_n != p0 + 1 || ferr_n != f0 || fifo_count !== 4'd0) begin
      n_fail++;
      $display("FAIL parity_err got pe %0d fe %0d cnt %0d exp 1 0 0",
               perr_n - p0, ferr_n - f0, fifo_count);
    end
    send_byte(8'hF0);
    send_bits(mk(8'h55, 1'b1, 1'b0), 11);
    tick(HALF);
    send_byte(8'h1C);
    pop1(d, v);
    n_tests++;
    if (v !== 1'b1 || d !== 10'h01C) begin
      n_fail++;
      $display("FAIL parity_clears got v%b %h exp v1 01C", v, d);
    end
    p0 = perr_n;
    f0 = ferr_n;
    send_bits(mk(8'h1C, 1'b0, 1'b1), 11);
    tick(HALF);
    send_bits(mk(8'h1C, 1'b1, 1'b1), 11);
    tick(HALF);
    n_tests++;
    if (ferr_n != f0 + 2 || perr_n != p0 || fifo_count !== 4'd0) begin
      n_fail++;
      $display("FAIL stop_err got fe %0d pe %0d cnt %0d exp 2 0 0",
               ferr_n - f0, perr_n - p0, fifo_count);
    end
  endtask

  task automatic test_timeout;
    logic [9:0] d;
    logic       v;
    int         f0;
    send_byte(8'hE0);
    f0 = ferr_n;
    send_bits(mk(8'h2B, 1'b0, 1'b0), 5);
    tick(TMO + 50);
    n_tests++;
    if (ferr_n != f0 + 1 || fifo_count !== 4'd0) begin
      n_fail++;
      $display("FAIL timeout got fe %0d cnt %0d exp 1 0",
               ferr_n - f0, fifo_count);
    end
    send_byte(8'h2B);
    pop1(d, v);
    n_tests++;
    if (v !== 1'b1 || d !== 10'h02B || ferr_n != f0 + 1) begin
      n_fail++;
      $display("FAIL timeout_next got v%b %h exp v1 02B", v, d);
    end
  endtask

  task automatic test_glitch;
    logic [9:0] d;
    logic       v;
    int         e0;
    e0 = perr_n + ferr_n;
    ps2_data = 1'b0;
    ps2_clk  = 1'b0;
    tick(2);
    ps2_clk  = 1'b1;
    tick(2);
    ps2_data = 1'b1;
    tick(HALF);
    send_byte(8'h1C);
    pop1(d, v);
    n_tests++;
    if (v !== 1'b1 || d !== 10'h01C || perr_n + ferr_n != e0) begin
      n_fail++;
      $display("FAIL glitch got v%b %h errs %0d exp v1 01C 0",
               v, d, perr_n + ferr_n - e0);
    end
  endtask

  task automatic test_overflow;
    logic [9:0] d;
    logic       v;
    int         o0;
    o0 = ovf_n;
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send_byte(8'(i));
    n_tests++;
    if (fifo_count !== 4'd8 || ovf_n != o0 + 1) begin
      n_fail++;
      $display("FAIL overflow got cnt %0d ov %0d exp 8 1",
               fifo_count, ovf_n - o0);
    end
    for (int i = 1; i <= 8; i++) begin
      pop1(d, v);
      n_tests++;
      if (v !== 1'b1 || d !== 10'(i)) begin
        n_fail++;
        $display("FAIL ovf_order got v%b %h exp v1 %h", v, d, 10'(i));
      end
    end
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 10'h008) begin
      n_fail++;
      $display("FAIL ovf_empty got v%b %h exp v0 008", out_valid, out_data);
    end
  endtask

  task automatic test_full_pushpop;
    logic [9:0] d;
    logic       v;
    int         o0;
    int         pc;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'h11 + 8'(i));
    pc = push_cyc;
    o0 = ovf_n;
    n_tests++;
    if (fifo_count !== 4'd8 || pc < 2) begin
      n_fail++;
      $display("FAIL full_fill got cnt %0d pushcyc %0d exp 8 >=2",
               fifo_count, pc);
    end else begin
      pop_at = pc;
      send_byte(8'h19);
      pop_at = 0;
      out_ready = 1'b0;
      n_tests++;
      if (fifo_count !== 4'd8 || ovf_n != o0) begin
        n_fail++;
        $display("FAIL full_pushpop got cnt %0d ov %0d exp 8 0",
                 fifo_count, ovf_n - o0);
      end
      for (int i = 0; i < 8; i++) begin
        pop1(d, v);
        n_tests++;
        if (v !== 1'b1 || d !== 10'h012 + 10'(i)) begin
          n_fail++;
          $display("FAIL full_order got v%b %h exp v1 %h",
                   v, d, 10'h012 + 10'(i));
        end
      end
    end
    out_ready = 1'b1;
    tick(DEPTH + 2);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midframe;
    logic [9:0] d;
    logic       v;
    send_byte(8'hE0);
    send_bits(mk(8'h75, 1'b0, 1'b0), 6);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(HALF);
    n_tests++;
    if (fifo_count !== 4'd0 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_state got cnt %0d v%b exp 0 0",
               fifo_count, out_valid);
    end
    send_byte(8'h75);
    pop1(d, v);
    n_tests++;
    if (v !== 1'b1 || d !== 10'h075) begin
      n_fail++;
      $display("FAIL rst_mid_next got v%b %h exp v1 075", v, d);
    end
  endtask

  initial begin
    test_reset;
    test_make;
    test_prefix;
    test_errors;
    test_timeout;
    test_glitch;
    test_overflow;
    test_full_pushpop;
    test_reset_midframe;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
